// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle ARM control path.
// Optional macro MULTICYCLE_FSM_STALL_EN is consumed by multicycle_fsm.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_CMP = 4'b1010;

  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [3:0] alucontrol;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
  } ctrl_t;

  // Only arithmetic commands produce meaningful carry/overflow.
  function automatic logic cv_cmd(input logic [3:0] c);
    return (c == ALU_ADD) || (c == ALU_SUB) ||
           (c == ALU_CMP);
  endfunction

endpackage

// File: rtl/multicycle_fsm_cond_unit.sv
// Combinational ARM condition check against {N,Z,C,V}.
// Codes 1110 and 1111 both evaluate true.
module cond_unit
  import multicycle_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Decode the condition field.
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_fsm.sv
// Multicycle ARM main control FSM with flag register.
// Define MULTICYCLE_FSM_STALL_EN to add the mem_ready stall input.
module multicycle_fsm
  import multicycle_pkg::*;
#(
  parameter int RESET_STATE_DBG = 0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef MULTICYCLE_FSM_STALL_EN
  input  logic       mem_ready,
`endif
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state, nxt;
  logic [3:0] flags;
  logic       cond_ex, cond_ex_q;
  logic       ready;
  logic [3:0] cmd;
  logic       sbit;
  ctrl_t      c;

  assign cmd  = Funct[4:1];
  assign sbit = Funct[0];

`ifdef MULTICYCLE_FSM_STALL_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  cond_unit u_cond (
    .cond    (Cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nxt;
  end

  // Flags and the condition result latched in DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      if (state == DECODE) cond_ex_q <= cond_ex;
      if ((state == EXECR || state == EXECI) &&
          sbit && cond_ex_q) begin
        flags[3:2] <= ALUFlags[3:2];
        if (cv_cmd(cmd)) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      FETCH:  nxt = ready ? DECODE : FETCH;
      DECODE: begin
        unique case (Op)
          2'b00:   nxt = Funct[5] ? EXECI : EXECR;
          2'b01:   nxt = MEMADR;
          2'b10:   nxt = BRANCH;
          default: nxt = FETCH;
        endcase
      end
      MEMADR: nxt = sbit ? MEMRD : MEMWR;
      MEMRD:  nxt = ready ? MEMWB : MEMRD;
      MEMWB:  nxt = FETCH;
      MEMWR:  nxt = ready ? FETCH : MEMWR;
      EXECR,
      EXECI:  nxt = (cmd == ALU_CMP) ? FETCH : ALUWB;
      ALUWB:  nxt = FETCH;
      BRANCH: nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  // Per-state control outputs.
  always_comb begin
    c = '0;
    unique case (state)
      FETCH: begin
        c.irwrite    = ready;
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_4;
        c.alucontrol = ALU_ADD;
        c.resultsrc  = RES_ALURES;
        c.pcwrite    = ready;
      end
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = SRCB_4;
        c.resultsrc = RES_ALURES;
        c.illegal   = (Op == 2'b11);
      end
      MEMADR: begin
        c.alusrcb    = SRCB_IMM;
        c.alucontrol = ALU_ADD;
      end
      MEMRD: c.adrsrc = 1'b1;
      MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regwrite  = cond_ex_q;
      end
      MEMWR: begin
        c.adrsrc   = 1'b1;
        c.memwrite = cond_ex_q & ready;
      end
      EXECR: begin
        c.alusrcb    = SRCB_RM;
        c.alucontrol = cmd;
      end
      EXECI: begin
        c.alusrcb    = SRCB_IMM;
        c.alucontrol = cmd;
      end
      ALUWB: begin
        c.resultsrc = RES_ALUOUT;
        c.pcwrite   = (Rd == 4'd15) & cond_ex_q;
        c.regwrite  = (Rd != 4'd15) & cond_ex_q;
      end
      BRANCH: begin
        c.alusrcb    = SRCB_IMM;
        c.alucontrol = ALU_ADD;
        c.resultsrc  = RES_ALURES;
        c.pcwrite    = cond_ex_q;
      end
      default: c = '0;
    endcase
  end

  assign IRWrite    = c.irwrite  & ~reset;
  assign PCWrite    = c.pcwrite  & ~reset;
  assign RegWrite   = c.regwrite & ~reset;
  assign MemWrite   = c.memwrite & ~reset;
  assign illegal    = c.illegal  & ~reset;
  assign AdrSrc     = c.adrsrc;
  assign ALUSrcA    = c.alusrca;
  assign ALUSrcB    = c.alusrcb;
  assign ResultSrc  = c.resultsrc;
  assign ALUControl = c.alucontrol;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01) & ~Funct[0],
                       (Op == 2'b10)};
  assign state_o    = (RESET_STATE_DBG != 0) ?
                      state : 4'd0;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Scoreboard bench for multicycle_fsm.
// Stall checks are built when MULTICYCLE_FSM_STALL_EN is defined.
module tb_multicycle_fsm;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b1;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
  logic       IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl;
  logic       PCWrite, RegWrite, MemWrite, illegal;
  logic [3:0] state_o;

  multicycle_fsm #(.RESET_STATE_DBG(1)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MULTICYCLE_FSM_STALL_EN
    .mem_ready  (mem_ready),
`endif
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, pcw, rw, mw, ill, adr, sa;
    logic [1:0] sb, rs;
    logic [3:0] ac;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad = 0;
  exp_t  act;

  assign act = {state_o, IRWrite, PCWrite, RegWrite,
                MemWrite, illegal, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl};

  // Monitor: compare every presented cycle against the queue.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, act, e);
      end
    end
  end

  function automatic exp_t mk(
    input logic [3:0] st,
    input logic irw, pcw, rw, mw, ill, adr, sa,
    input logic [1:0] sb, rs,
    input logic [3:0] ac);
    return {st, irw, pcw, rw, mw, ill, adr, sa,
            sb, rs, ac};
  endfunction

  task automatic step(input string n, input exp_t e);
    q.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [1:0] op,
                     input logic [5:0] f,
                     input logic [3:0] rd, cd, fl);
    Op = op; Funct = f; Rd = rd;
    Cond = cd; ALUFlags = fl;
  endtask

  task automatic t_fetch(input string n);
    step(n, mk(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 2'b10, 2'b10, ALU_ADD));
  endtask

  task automatic t_decode(input string n,
                          input logic ill);
    step(n, mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, ill,
               1'b0, 1'b1, 2'b10, 2'b10, 4'b0000));
  endtask

  task automatic t_exec(input string n,
                        input logic imm,
                        input logic [3:0] ac);
    step(n, mk(imm ? 4'd7 : 4'd6, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0,
               imm ? 2'b01 : 2'b00, 2'b00, ac));
  endtask

  task automatic t_aluwb(input string n,
                         input logic pcw, rw);
    step(n, mk(4'd8, 1'b0, pcw, rw, 1'b0, 1'b0,
               1'b0, 1'b0, 2'b00, 2'b00, 4'b0000));
  endtask

  task automatic t_memadr(input string n);
    step(n, mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 2'b01, 2'b00, ALU_ADD));
  endtask

  task automatic t_memrd(input string n);
    step(n, mk(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 2'b00, 2'b00, 4'b0000));
  endtask

  task automatic t_memwb(input string n, input logic rw);
    step(n, mk(4'd4, 1'b0, 1'b0, rw, 1'b0, 1'b0,
               1'b0, 1'b0, 2'b00, 2'b01, 4'b0000));
  endtask

  task automatic t_memwr(input string n, input logic mw);
    step(n, mk(4'd5, 1'b0, 1'b0, 1'b0, mw, 1'b0,
               1'b1, 1'b0, 2'b00, 2'b00, 4'b0000));
  endtask

  task automatic t_branch(input string n, input logic pcw);
    step(n, mk(4'd9, 1'b0, pcw, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 2'b01, 2'b10, ALU_ADD));
  endtask

  initial begin
    set(2'b00, 6'b000000, 4'd0, 4'hE, 4'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("reset", mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b1, 2'b10, 2'b10,
                     ALU_ADD));
    reset = 1'b0;

    set(2'b00, 6'b001000, 4'd1, 4'hE, 4'h0);
    t_fetch("add.f"); t_decode("add.d", 1'b0);
    t_exec("add.ex", 1'b0, ALU_ADD);
    t_aluwb("add.wb", 1'b0, 1'b1);

    set(2'b01, 6'b011001, 4'd2, 4'hE, 4'h0);
    t_fetch("ldr.f"); t_decode("ldr.d", 1'b0);
    t_memadr("ldr.ma"); t_memrd("ldr.rd");
    t_memwb("ldr.wb", 1'b1);

    set(2'b00, 6'b000101, 4'd0, 4'hE, 4'b0110);
    t_fetch("subs.f"); t_decode("subs.d", 1'b0);
    t_exec("subs.ex", 1'b0, ALU_SUB);
    t_aluwb("subs.wb", 1'b0, 1'b1);

    set(2'b10, 6'b100000, 4'd0, COND_EQ, 4'h0);
    t_fetch("beq.f"); t_decode("beq.d", 1'b0);
    t_branch("beq.br", 1'b1);

    set(2'b10, 6'b100000, 4'd0, COND_NE, 4'h0);
    t_fetch("bne.f"); t_decode("bne.d", 1'b0);
    t_branch("bne.br", 1'b0);

    set(2'b00, 6'b010101, 4'd0, 4'hE, 4'b1000);
    t_fetch("cmp.f"); t_decode("cmp.d", 1'b0);
    t_exec("cmp.ex", 1'b0, ALU_CMP);

    set(2'b01, 6'b011000, 4'd5, COND_EQ, 4'h0);
    t_fetch("str.f"); t_decode("str.d", 1'b0);
    t_memadr("str.ma"); t_memwr("str.wr", 1'b0);

    set(2'b00, 6'b101000, 4'd15, COND_MI, 4'h0);
    t_fetch("addpc.f"); t_decode("addpc.d", 1'b0);
    t_exec("addpc.ex", 1'b1, ALU_ADD);
    t_aluwb("addpc.wb", 1'b1, 1'b0);

    set(2'b00, 6'b100001, 4'd3, 4'hE, 4'b0011);
    t_fetch("ands.f"); t_decode("ands.d", 1'b0);
    t_exec("ands.ex", 1'b1, ALU_AND);
    t_aluwb("ands.wb", 1'b0, 1'b1);

    set(2'b00, 6'b001000, 4'd4, COND_CS, 4'h0);
    t_fetch("addcs.f"); t_decode("addcs.d", 1'b0);
    t_exec("addcs.ex", 1'b0, ALU_ADD);
    t_aluwb("addcs.wb", 1'b0, 1'b0);

    set(2'b11, 6'b000000, 4'd0, 4'hE, 4'h0);
    t_fetch("ill.f"); t_decode("ill.d", 1'b1);

    set(2'b00, 6'b000101, 4'd0, 4'hE, 4'b0100);
    t_fetch("subz.f"); t_decode("subz.d", 1'b0);
    t_exec("subz.ex", 1'b0, ALU_SUB);
    t_aluwb("subz.wb", 1'b0, 1'b1);

    set(2'b01, 6'b011001, 4'd2, 4'hE, 4'h0);
    t_fetch("rld.f"); t_decode("rld.d", 1'b0);
    t_memadr("rld.ma");
    reset = 1'b1;
    t_memrd("rld.rd");
    reset = 1'b0;

    set(2'b10, 6'b100000, 4'd0, COND_EQ, 4'h0);
    t_fetch("rbeq.f"); t_decode("rbeq.d", 1'b0);
    t_branch("rbeq.br", 1'b0);

    set(2'b10, 6'b100000, 4'd0, COND_NV, 4'h0);
    t_fetch("bnv.f"); t_decode("bnv.d", 1'b0);
    t_branch("bnv.br", 1'b1);

`ifdef MULTICYCLE_FSM_STALL_EN
    set(2'b00, 6'b001000, 4'd1, 4'hE, 4'h0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step("stall.f", mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b1, 2'b10, 2'b10,
                         ALU_ADD));
    mem_ready = 1'b1;
    t_fetch("stall.go"); t_decode("stall.d", 1'b0);
    t_exec("stall.ex", 1'b0, ALU_ADD);
    t_aluwb("stall.wb", 1'b0, 1'b1);
`endif

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
